// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl
// Multicycle control FSM for the MIPS core. Steps the shared datapath
// (memory port, IR, register file, ALU, PC) through the instruction phases
// and sets the immediate extender mode. Every datapath output is a Moore
// decode of the current state; mem_ready and zero gate a few strobes.
//
// Memory handshake: in FETCH, MEMRD and MEMWR mem_req is held high every
// cycle until the cycle in which mem_ready=1. That cycle completes the access
// and the FSM leaves the state on the next edge. mem_ready is ignored in all
// other states. With MEM_WAIT_EN=0 every access completes in one cycle.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   opcode, funct     IR[31:26] and IR[5:0]
//   zero              ALU zero flag of the current cycle
//   mem_ready         memory completes the access this cycle
//   mem_req, mem_write, iord            memory port control
//   ir_write, pc_write, pc_src          IR / PC load control
//   alu_src_a, alu_src_b, alu_ctl       ALU operand and operation select
//   imm_sel                             extender: 00 sign, 01 zero, 10 upper
//   reg_dst, mem_to_reg, reg_write      register file write-back control
//   illegal                             one-cycle pulse on unsupported code
//   state                               current FSM state, for debug
module mips_multicycle_ctrl #(
   parameter int MEM_WAIT_EN = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       mem_write,
   output logic       iord,
   output logic       ir_write,
   output logic       pc_write,
   output logic [1:0] pc_src,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [2:0] alu_ctl,
   output logic [1:0] imm_sel,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic       reg_write,
   output logic       illegal,
   output logic [3:0] state
);

   localparam logic [3:0] S_FETCH   = 4'd0;
   localparam logic [3:0] S_DECODE  = 4'd1;
   localparam logic [3:0] S_MEMADR  = 4'd2;
   localparam logic [3:0] S_MEMRD   = 4'd3;
   localparam logic [3:0] S_MEMWB   = 4'd4;
   localparam logic [3:0] S_MEMWR   = 4'd5;
   localparam logic [3:0] S_REX     = 4'd6;
   localparam logic [3:0] S_RWB     = 4'd7;
   localparam logic [3:0] S_BRANCH  = 4'd8;
   localparam logic [3:0] S_IMMEX   = 4'd9;
   localparam logic [3:0] S_IMMWB   = 4'd10;
   localparam logic [3:0] S_JUMP    = 4'd11;
   localparam logic [3:0] S_ILLEGAL = 4'd12;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_SLT = 3'b111;

   logic [3:0] state_q, state_d;
   logic       ready;
   logic       r_ok;
   logic [2:0] r_ctl;
   // Strobes that must be forced low while reset is asserted.
   logic       mem_req_c, mem_write_c, ir_write_c, pc_write_c;
   logic       reg_write_c, illegal_c;

   assign ready = (MEM_WAIT_EN != 0) ? mem_ready : 1'b1;

   // R-type funct decode: supported flag and ALU operation.
   always_comb begin
      r_ok  = 1'b1;
      r_ctl = ALU_ADD;
      case (funct)
         6'b100000: r_ctl = ALU_ADD;
         6'b100010: r_ctl = ALU_SUB;
         6'b100100: r_ctl = ALU_AND;
         6'b100101: r_ctl = ALU_OR;
         6'b101010: r_ctl = ALU_SLT;
         default:   r_ok  = 1'b0;
      endcase
   end

   always_comb begin
      state_d     = S_FETCH;
      mem_req_c   = 1'b0;
      mem_write_c = 1'b0;
      ir_write_c  = 1'b0;
      pc_write_c  = 1'b0;
      reg_write_c = 1'b0;
      illegal_c   = 1'b0;
      iord        = 1'b0;
      pc_src      = 2'b00;
      alu_src_a   = 1'b0;
      alu_src_b   = 2'b00;
      alu_ctl     = 3'b000;
      imm_sel     = 2'b00;
      reg_dst     = 1'b0;
      mem_to_reg  = 1'b0;
      case (state_q)
         S_FETCH: begin
            mem_req_c  = 1'b1;
            alu_src_b  = 2'b01;
            alu_ctl    = ALU_ADD;
            ir_write_c = ready;
            pc_write_c = ready;
            state_d    = ready ? S_DECODE : S_FETCH;
         end
         S_DECODE: begin
            // Branch target PC + (sext(imm) << 2) is formed here speculatively.
            alu_src_b = 2'b11;
            alu_ctl   = ALU_ADD;
            case (opcode)
               OP_RTYPE:                                 state_d = r_ok ? S_REX : S_ILLEGAL;
               OP_LW, OP_SW:                             state_d = S_MEMADR;
               OP_BEQ, OP_BNE:                           state_d = S_BRANCH;
               OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI: state_d = S_IMMEX;
               OP_J:                                     state_d = S_JUMP;
               default:                                  state_d = S_ILLEGAL;
            endcase
         end
         S_MEMADR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            alu_ctl   = ALU_ADD;
            state_d   = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
         end
         S_MEMRD: begin
            mem_req_c = 1'b1;
            iord      = 1'b1;
            state_d   = ready ? S_MEMWB : S_MEMRD;
         end
         S_MEMWB: begin
            reg_write_c = 1'b1;
            mem_to_reg  = 1'b1;
         end
         S_MEMWR: begin
            mem_req_c   = 1'b1;
            mem_write_c = 1'b1;
            iord        = 1'b1;
            state_d     = ready ? S_FETCH : S_MEMWR;
         end
         S_REX: begin
            alu_src_a = 1'b1;
            alu_ctl   = r_ctl;
            state_d   = S_RWB;
         end
         S_RWB: begin
            reg_write_c = 1'b1;
            reg_dst     = 1'b1;
         end
         S_BRANCH: begin
            alu_src_a  = 1'b1;
            alu_ctl    = ALU_SUB;
            pc_src     = 2'b01;
            pc_write_c = (opcode == OP_BNE) ? !zero : zero;
         end
         S_IMMEX: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            state_d   = S_IMMWB;
            case (opcode)
               OP_SLTI: alu_ctl = ALU_SLT;
               OP_ANDI: begin imm_sel = 2'b01; alu_ctl = ALU_AND; end
               OP_ORI:  begin imm_sel = 2'b01; alu_ctl = ALU_OR;  end
               // rs is $0 for lui, so OR passes the upper-extended immediate.
               OP_LUI:  begin imm_sel = 2'b10; alu_ctl = ALU_OR;  end
               default: alu_ctl = ALU_ADD;
            endcase
         end
         S_IMMWB: reg_write_c = 1'b1;
         S_JUMP: begin
            pc_src     = 2'b10;
            pc_write_c = 1'b1;
         end
         S_ILLEGAL: illegal_c = 1'b1;
         default: state_d = S_FETCH;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_FETCH;
      else        state_q <= state_d;
   end

   // Gating with rst_n stops any write in the cycle reset is asserted,
   // including one already in progress when the FSM was mid-instruction.
   assign mem_req   = mem_req_c   & rst_n;
   assign mem_write = mem_write_c & rst_n;
   assign ir_write  = ir_write_c  & rst_n;
   assign pc_write  = pc_write_c  & rst_n;
   assign reg_write = reg_write_c & rst_n;
   assign illegal   = illegal_c   & rst_n;
   assign state     = state_q;

endmodule

// File: doc/mips_multicycle_ctrl.md
# mips_multicycle_ctrl

Multicycle control FSM for the MIPS core. It sequences the shared datapath (memory port, IR, register file, ALU, PC) across instruction phases, and configures the immediate extender: sign-extend, zero-extend, or upper (`{imm,16'b0}`). It sits beside the datapath and decodes `opcode`/`funct` from the IR. All datapath-facing outputs are Moore decodes of the state, gated only by `mem_ready` and `zero` where stated.

## Interface
- `MEM_WAIT_EN`, default 1: 1 = honour `mem_ready`; 0 = treat `mem_ready` as always 1.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `opcode`  in  6  IR[31:26], stable from DECODE until the next FETCH.
- `funct`  in  6  IR[5:0].
- `zero`  in  1  ALU zero flag from the current cycle.
- `mem_ready`  in  1  memory completes the access this cycle.
- `mem_req`  out  1  memory access active.
- `mem_write`  out  1  store strobe.
- `iord`  out  1  address select: 0 = PC, 1 = ALUOut.
- `ir_write`  out  1  IR load.
- `pc_write`  out  1  PC load.
- `pc_src`  out  2  PC source: 00 = ALU, 01 = ALUOut, 10 = jump target.
- `alu_src_a`  out  1  ALU A: 0 = PC, 1 = A register.
- `alu_src_b`  out  2  ALU B: 00 = B register, 01 = 4, 10 = ext(imm), 11 = ext(imm)<<2.
- `alu_ctl`  out  3  ALU operation: 010 add, 110 sub, 000 and, 001 or, 111 slt.
- `imm_sel`  out  2  extender mode: 00 sign, 01 zero, 10 upper.
- `reg_dst`  out  1  destination register: 0 = rt, 1 = rd.
- `mem_to_reg`  out  1  write-back source: 0 = ALUOut, 1 = MDR.
- `reg_write`  out  1  register file write.
- `illegal`  out  1  one-cycle pulse on an unsupported instruction.
- `state`  out  4  current state, for debug.

## Operation
- State encoding: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, REX 6, RWB 7, BRANCH 8, IMMEX 9, IMMWB 10, JUMP 11, ILLEGAL 12. Codes 13–15 go to FETCH on the next edge.
- Every output defaults to 0 unless listed for the state.
- **FETCH:** mem_req=1, iord=0, alu_src_b=01, alu_ctl=add, pc_src=00.
  - ir_write and pc_write are driven equal to mem_ready.
  - Stay in FETCH while mem_ready=0; go to DECODE when it is 1.
- **DECODE:** alu_src_b=11, imm_sel=00, alu_ctl=add (precomputes the branch target). Next state by opcode:
  - 000000 with funct in {100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt}: REX.
  - 100011 lw or 101011 sw: MEMADR.
  - 000100 beq or 000101 bne: BRANCH.
  - 001000 addi, 001010 slti, 001100 andi, 001101 ori, 001111 lui: IMMEX.
  - 000010 j: JUMP.
  - Anything else, including an unsupported funct: ILLEGAL.
- **MEMADR:** alu_src_a=1, alu_src_b=10, imm_sel=00, add. Next: MEMRD for lw, MEMWR for sw.
- **MEMRD:** mem_req=1, iord=1. Wait for mem_ready, then MEMWB.
- **MEMWB:** reg_write=1, mem_to_reg=1, reg_dst=0. Next: FETCH.
- **MEMWR:** mem_req=1, iord=1, mem_write=1. Wait for mem_ready, then FETCH.
- **REX:** alu_src_a=1, alu_src_b=00, alu_ctl decoded from funct. Next: RWB.
- **RWB:** reg_write=1, reg_dst=1. Next: FETCH.
- **BRANCH:** alu_src_a=1, alu_src_b=00, sub, pc_src=01.
  - pc_write=zero for beq; pc_write=!zero for bne.
  - Next: FETCH.
- **IMMEX:** alu_src_a=1, alu_src_b=10. Per opcode:
  - addi: sign, add.
  - slti: sign, slt.
  - andi: zero, and.
  - ori: zero, or.
  - lui: upper, or (rs=$0, so the result is imm<<16).
  - Next: IMMWB.
- **IMMWB:** reg_write=1, reg_dst=0, mem_to_reg=0. Next: FETCH.
- **JUMP:** pc_src=10, pc_write=1. Next: FETCH.
- **ILLEGAL:** illegal=1, no writes. Next: FETCH, so the PC has already advanced past the bad word.

## Timing
- Reset:
  - While rst_n=0: state=FETCH, and pc_write, ir_write, reg_write, mem_write, mem_req, illegal are all forced to 0.
  - The other outputs show their FETCH values.
  - On release, FETCH begins at the next rising edge.
  - Asserting reset mid-instruction abandons it with no partial write in the reset cycle.
- Latency in cycles, with zero wait states: R-type 4, lw 5, sw 4, beq/bne 3, immediate ops 4, j 3, illegal 3.
- Each cycle with mem_ready=0 in FETCH, MEMRD, or MEMWR adds one cycle.
- Memory handshake: mem_req stays high continuously until the cycle in which mem_ready=1. In that cycle the access completes and the state advances.
- mem_ready is ignored in every other state.
- mem_write and mem_req assert together only in MEMWR.
- Exactly one pc_write cycle per FETCH completion. A taken branch or a jump adds a second pc_write, in BRANCH or JUMP.

## Test plan
- Reset with rst_n=0 mid-MEMWR, mem_ready=1 → mem_write=0 and state=0 immediately. After release, the first FETCH with mem_ready=1 gives ir_write=pc_write=1.
- lw (opcode 100011), mem_ready low for 2 cycles in MEMRD → states 0,1,2,3,3,3,4,0. reg_write=1 only in state 4, with mem_to_reg=1.
- beq with zero=1, then bne with zero=1 → pc_write=1 in BRANCH for beq, 0 for bne; pc_src=01 in both.
- ori (001101), then lui (001111) → IMMEX shows imm_sel=01, alu_ctl=001 for ori, and imm_sel=10, alu_ctl=001 for lui. DECODE shows imm_sel=00 in both.
- R-type with funct 000111 → DECODE→ILLEGAL: a one-cycle illegal pulse, no reg_write, then FETCH.
- MEM_WAIT_EN=0 with mem_ready tied 0 → sw completes in 4 cycles: states 0,1,2,5.
